// File: rtl/trace_pkg.sv
// Shared types for the trace dispatcher: op codes, FSM states, record layout, op decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package trace_pkg;

  // Widest address a buffered record can carry; the top's ADDR_W must not exceed it.
  localparam int TRACE_ADDR_W = 32;

  localparam logic [3:0] OP_DREAD  = 4'd0;
  localparam logic [3:0] OP_DWRITE = 4'd1;
  localparam logic [3:0] OP_IFETCH = 4'd2;
  localparam logic [3:0] OP_INVAL  = 4'd3;
  localparam logic [3:0] OP_SNOOP  = 4'd4;
  localparam logic [3:0] OP_CLEAR  = 4'd8;
  localparam logic [3:0] OP_PRINT  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CTRL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]              op;
    logic [TRACE_ADDR_W-1:0] addr;
  } trace_rec_t;

  typedef struct packed {
    logic use_i;
    logic use_d;
    logic is_clear;
    logic is_print;
    logic bad;
  } op_dec_t;

  // Maps an op code to the cache(s) or control pulse it produces.
  function automatic op_dec_t decode_op(input logic [3:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      OP_DREAD, OP_DWRITE: d.use_d = 1'b1;
      OP_IFETCH:           d.use_i = 1'b1;
      OP_INVAL, OP_SNOOP: begin
        d.use_i = 1'b1;
        d.use_d = 1'b1;
      end
      OP_CLEAR:            d.is_clear = 1'b1;
      OP_PRINT:            d.is_print = 1'b1;
      default:             d.bad = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and extra-MSB wrap pointers.
// Latency: a push is visible at head (empty low) one edge after it is written.
// Backpressure: ready is a registered !full of the next state; pushes while full are dropped.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             full, full_nxt, do_push, do_pop;

  // Full when the indices match but the wrap bits differ.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
  assign full_nxt = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign head     = mem[rd_ptr[AW-1:0]];

  // Pointer and registered-ready update; ready stays low while in reset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      ready  <= !full_nxt;
    end
  end

  // Storage write; contents need no reset because the pointers guard them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_dispatch.sv
// Buffers trace records and issues each in order as I/D-cache req/ack or a clear/print pulse.
// Latency: push at edge E into an empty FIFO gives req (or pulse) after edge E+1; 2 cycles/record min.
// Backpressure: in_ready = registered !full; one record in flight, held until every matching ack.
module trace_dispatch
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              i_req,
  output logic [3:0]        i_op,
  output logic [ADDR_W-1:0] i_addr,
  input  logic              i_ack,
  output logic              d_req,
  output logic [3:0]        d_op,
  output logic [ADDR_W-1:0] d_addr,
  input  logic              d_ack,
  output logic              clear_caches,
  output logic              print,
  output logic              busy,
  output logic [31:0]       rec_count,
  output logic [15:0]       bad_op_count
);

  state_t     state, state_nxt;
  trace_rec_t wr_rec, head_rec;
  op_dec_t    dec;
  logic       empty, pop, i_hold, d_hold;

  assign wr_rec.op   = in_op;
  assign wr_rec.addr = TRACE_ADDR_W'(in_addr);

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(trace_rec_t))
  ) u_fifo (
    .clk       (clk),
    .clear_n   (clear_n),
    .push      (in_valid && in_ready),
    .push_data (wr_rec),
    .pop       (pop),
    .head      (head_rec),
    .empty     (empty),
    .ready     (in_ready)
  );

  assign busy = !empty || (state != ST_IDLE);

  // Next-state and pop decision; a request is "held" until its own ack is seen.
  always_comb begin
    state_nxt = state;
    dec       = decode_op(head_rec.op);
    pop       = 1'b0;
    i_hold    = i_req && !i_ack;
    d_hold    = d_req && !d_ack;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (dec.use_i || dec.use_d)         state_nxt = ST_ISSUE;
          else if (dec.is_clear || dec.is_print) state_nxt = ST_CTRL;
        end
      end
      ST_ISSUE: if (!i_hold && !d_hold) state_nxt = ST_IDLE;
      ST_CTRL:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register; reset abandons any in-flight record.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Request/pulse/counter registers: loaded on pop, requests retired by their own ack.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      i_req        <= 1'b0;
      i_op         <= '0;
      i_addr       <= '0;
      d_req        <= 1'b0;
      d_op         <= '0;
      d_addr       <= '0;
      clear_caches <= 1'b0;
      print        <= 1'b0;
      rec_count    <= '0;
      bad_op_count <= '0;
    end else begin
      clear_caches <= 1'b0;
      print        <= 1'b0;
      if (pop) begin
        if (rec_count != '1)                bad_op_count <= bad_op_count;
        if (rec_count != '1)                rec_count    <= rec_count + 32'd1;
        if (dec.bad && bad_op_count != '1)  bad_op_count <= bad_op_count + 16'd1;
        i_req        <= dec.use_i;
        i_op         <= dec.use_i ? head_rec.op : 4'd0;
        i_addr       <= dec.use_i ? head_rec.addr[ADDR_W-1:0] : '0;
        d_req        <= dec.use_d;
        d_op         <= dec.use_d ? head_rec.op : 4'd0;
        d_addr       <= dec.use_d ? head_rec.addr[ADDR_W-1:0] : '0;
        clear_caches <= dec.is_clear;
        print        <= dec.is_print;
      end else begin
        if (i_req && i_ack) begin
          i_req  <= 1'b0;
          i_op   <= '0;
          i_addr <= '0;
        end
        if (d_req && d_ack) begin
          d_req  <= 1'b0;
          d_op   <= '0;
          d_addr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_dispatch.sv
// Directed bench for trace_dispatch: reset, single/dual issue, FIFO fill and wrap, control ops, saturation.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: acks are driven explicitly by the stimulus sequence.
module tb_trace_dispatch;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic        i_req, d_req, i_ack, d_ack;
  logic [3:0]  i_op, d_op;
  logic [31:0] i_addr, d_addr;
  logic        clear_caches, print, busy;
  logic [31:0] rec_count;
  logic [15:0] bad_op_count;

  int n_tests = 0;
  int n_fail  = 0;

  bit mon_en = 1'b0;
  int n_clr  = 0;
  int n_prt  = 0;
  int n_req  = 0;

  logic [3:0]  exp_op   [5] = '{4'd0, 4'd2, 4'd1, 4'd2, 4'd0};
  logic [31:0] exp_addr [5] = '{32'h100, 32'h204, 32'h308, 32'h40C, 32'h510};

  trace_dispatch #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_addr      (in_addr),
    .i_req        (i_req),
    .i_op         (i_op),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .d_req        (d_req),
    .d_op         (d_op),
    .d_addr       (d_addr),
    .d_ack        (d_ack),
    .clear_caches (clear_caches),
    .print        (print),
    .busy         (busy),
    .rec_count    (rec_count),
    .bad_op_count (bad_op_count)
  );

  always #5 clk = ~clk;

  // Pulse/request counters for the control-op window.
  always @(negedge clk) begin
    if (mon_en) begin
      if (clear_caches)   n_clr++;
      if (print)          n_prt++;
      if (i_req || d_req) n_req++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] addr);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    check("push_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    clear_n  = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_addr  = '0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;

    // Reset values
    #3;
    check("rst_rdy",   {31'd0, in_ready}, 32'd0);
    check("rst_ireq",  {31'd0, i_req}, 32'd0);
    check("rst_dreq",  {31'd0, d_req}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_rec",   rec_count, 32'd0);
    check("rst_bad",   {16'd0, bad_op_count}, 32'd0);
    tick();
    tick();
    clear_n = 1'b1;
    check("rdy_pre_edge", {31'd0, in_ready}, 32'd0);
    tick();
    check("rdy_first_edge", {31'd0, in_ready}, 32'd1);

    // Single I-fetch with ack tied high: 1-cycle request
    i_ack = 1'b1;
    push(4'd2, 32'h0000_1000);
    check("t1_noreq_yet", {31'd0, i_req}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_ireq", {31'd0, i_req}, 32'd1);
    check("t1_iaddr", i_addr, 32'h1000);
    check("t1_iop", {28'd0, i_op}, 32'd2);
    check("t1_dreq", {31'd0, d_req}, 32'd0);
    check("t1_rec", rec_count, 32'd1);
    tick();
    check("t1_ireq_drop", {31'd0, i_req}, 32'd0);
    check("t1_iaddr_zero", i_addr, 32'd0);
    check("t1_dreq2", {31'd0, d_req}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    i_ack = 1'b0;

    // Invalidate: both caches, d acked at +2, i acked at +4
    push(4'd3, 32'hDEAD_BEEF);
    tick();
    check("t2_ireq", {31'd0, i_req}, 32'd1);
    check("t2_dreq", {31'd0, d_req}, 32'd1);
    check("t2_iaddr", i_addr, 32'hDEAD_BEEF);
    check("t2_daddr", d_addr, 32'hDEAD_BEEF);
    tick();
    d_ack = 1'b1;
    tick();
    d_ack = 1'b0;
    check("t2_dreq_drop", {31'd0, d_req}, 32'd0);
    check("t2_ireq_hold", {31'd0, i_req}, 32'd1);
    check("t2_iaddr_hold", i_addr, 32'hDEAD_BEEF);
    tick();
    check("t2_busy_wait", {31'd0, busy}, 32'd1);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("t2_ireq_drop", {31'd0, i_req}, 32'd0);
    check("t2_busy_low", {31'd0, busy}, 32'd0);
    check("t2_rec", rec_count, 32'd2);

    // Fill: acks low, 5 accepted (1 in flight + 4 buffered), pointers wrap
    for (int k = 0; k < 5; k++) push(exp_op[k], exp_addr[k]);
    check("t3_full_rdy", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_op    = 4'd2;
    in_addr  = 32'h999;
    tick();
    in_valid = 1'b0;
    check("t3_still_full", {31'd0, in_ready}, 32'd0);
    for (int j = 0; j < 5; j++) begin
      int w;
      w = 0;
      while (!(i_req || d_req) && w < 20) begin
        tick();
        w++;
      end
      check("t3_req_timeout", {31'd0, (w < 20)}, 32'd1);
      if (exp_op[j] == 4'd2) begin
        check("t3_ireq", {31'd0, i_req}, 32'd1);
        check("t3_iop", {28'd0, i_op}, {28'd0, exp_op[j]});
        check("t3_iaddr", i_addr, exp_addr[j]);
        i_ack = 1'b1;
      end else begin
        check("t3_dreq", {31'd0, d_req}, 32'd1);
        check("t3_dop", {28'd0, d_op}, {28'd0, exp_op[j]});
        check("t3_daddr", d_addr, exp_addr[j]);
        d_ack = 1'b1;
      end
      tick();
      i_ack = 1'b0;
      d_ack = 1'b0;
      check("t3_req_drop", {31'd0, (i_req || d_req)}, 32'd0);
    end
    tick();
    tick();
    check("t3_no_sixth", {31'd0, (i_req || d_req || busy)}, 32'd0);
    check("t3_rec", rec_count, 32'd7);

    // Control ops: bad, clear, print
    mon_en = 1'b1;
    push(4'd5, 32'h1);
    push(4'd8, 32'h2);
    push(4'd9, 32'h3);
    check("t4_clr_pulse", {31'd0, clear_caches}, 32'd1);
    tick();
    check("t4_clr_end", {31'd0, clear_caches}, 32'd0);
    check("t4_prt_early", {31'd0, print}, 32'd0);
    tick();
    check("t4_prt_pulse", {31'd0, print}, 32'd1);
    tick();
    check("t4_prt_end", {31'd0, print}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    mon_en = 1'b0;
    check("t4_n_clr", n_clr, 32'd1);
    check("t4_n_prt", n_prt, 32'd1);
    check("t4_n_req", n_req, 32'd0);
    check("t4_bad", {16'd0, bad_op_count}, 32'd1);
    check("t4_rec", rec_count, 32'd10);

    // Reset while a D request waits with two records queued
    push(4'd0, 32'h600);
    push(4'd1, 32'h700);
    push(4'd2, 32'h800);
    check("t5_dreq_wait", {31'd0, d_req}, 32'd1);
    check("t5_daddr", d_addr, 32'h600);
    clear_n = 1'b0;
    #1;
    check("t5_dreq_drop", {31'd0, d_req}, 32'd0);
    check("t5_daddr_zero", d_addr, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rec", rec_count, 32'd0);
    check("t5_bad", {16'd0, bad_op_count}, 32'd0);
    check("t5_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    clear_n = 1'b1;
    d_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_quiet", {30'd0, i_req, d_req}, 32'd0);
    end
    d_ack = 1'b0;
    check("t5_empty", {31'd0, busy}, 32'd0);
    check("t5_rdy_back", {31'd0, in_ready}, 32'd1);

    // Saturation from preloaded counters
    force dut.rec_count    = 32'hFFFF_FFFE;
    force dut.bad_op_count = 16'hFFFE;
    #1;
    release dut.rec_count;
    release dut.bad_op_count;
    push(4'd6, 32'h10);
    push(4'd7, 32'h20);
    check("t6_rec_max", rec_count, 32'hFFFF_FFFF);
    check("t6_bad_max", {16'd0, bad_op_count}, 32'h0000_FFFF);
    push(4'd15, 32'h30);
    push(4'd9, 32'h40);
    tick();
    tick();
    check("t6_rec_hold", rec_count, 32'hFFFF_FFFF);
    check("t6_bad_hold", {16'd0, bad_op_count}, 32'h0000_FFFF);
    check("t6_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
